// File: rtl/fp_mul_arbiter_pkg.sv
// Shared definitions for the FP multiplier arbiter and sibling shared-DSP schedulers.
//   FP_W            : single-precision word width
//   DEF_MUL_LATENCY : default hard-DSP multiplier latency
//   arb_state_e     : sequencer states
//   fp_op_t         : operand pair presented to the multiplier
//   clog2           : ceiling log2 for parameter-derived widths
package fp_mul_arbiter_pkg;

  localparam int unsigned FP_W            = 32;
  localparam int unsigned DEF_MUL_LATENCY = 4;

  typedef enum logic [1:0] {
    ST_INIT,
    ST_RUN,
    ST_DRAIN,
    ST_CLEAR
  } arb_state_e;

  typedef struct packed {
    logic [FP_W-1:0] a;
    logic [FP_W-1:0] b;
  } fp_op_t;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(n)) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/fp_mul_arbiter_if.sv
// Requester-side bus of the FP multiplier arbiter.
//   req_valid/req_ready : per-requester operand handshake
//   req_a/req_b         : packed operands, requester i at [32i+31:32i]
//   rsp_valid/rsp_data  : one-hot result strobe and shared product
interface fp_mul_arbiter_if #(
  parameter int unsigned NUM_REQ = 4
);
  import fp_mul_arbiter_pkg::*;

  logic [NUM_REQ-1:0]      req_valid;
  logic [NUM_REQ-1:0]      req_ready;
  logic [NUM_REQ*FP_W-1:0] req_a;
  logic [NUM_REQ*FP_W-1:0] req_b;
  logic [NUM_REQ-1:0]      rsp_valid;
  logic [FP_W-1:0]         rsp_data;

  modport master (
    output req_valid, req_a, req_b,
    input  req_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  req_valid, req_a, req_b,
    output req_ready, rsp_valid, rsp_data
  );

endinterface

// File: rtl/fp_mul_arbiter_rr_arbiter.sv
// Round-robin arbiter with internal last-grant pointer.
//   clk, rst_n   : clock, async active-low reset (pointer resets to NUM_REQ-1)
//   req          : request vector
//   advance      : grant was taken this cycle; move pointer to the grantee
//   grant_c      : combinational one-hot grant (zero when no request)
//   grant_id_c   : binary index of the grant
module rr_arbiter
  import fp_mul_arbiter_pkg::*;
#(
  parameter  int unsigned NUM_REQ = 4,
  localparam int unsigned ID_W    = clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               advance,
  output logic [NUM_REQ-1:0] grant_c,
  output logic [ID_W-1:0]    grant_id_c
);

  logic [ID_W-1:0] last_q, last_d;
  logic [ID_W-1:0] cand;
  logic            hit;

  // First requester after last_q, wrapping around.
  always_comb begin
    grant_c    = '0;
    grant_id_c = '0;
    hit        = 1'b0;
    cand       = '0;
    for (int unsigned off = 1; off <= NUM_REQ; off++) begin
      cand = ID_W'((32'(last_q) + off) % NUM_REQ);
      if (!hit && req[cand]) begin
        hit           = 1'b1;
        grant_c[cand] = 1'b1;
        grant_id_c    = cand;
      end
    end
  end

  // Kept apart from the grant search: advance is derived from grant_c.
  always_comb begin
    last_d = advance ? grant_id_c : last_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_q <= ID_W'(NUM_REQ - 1);
    else        last_q <= last_d;
  end

endmodule

// File: rtl/fp_mul_arbiter.sv
// Shares one pipelined FP multiplier among NUM_REQ requesters.
//   clk, rst_n        : clock, async active-low reset
//   bus (slave)       : requester handshake, operands, one-hot responses
//   flush_req         : level request to drain and clear the multiplier
//   flush_done        : one-cycle pulse when the flush completes
//   busy              : low only in RUN with nothing in flight
//   mul_ay/az/ena/clr : multiplier operand and control outputs
//   mul_result        : multiplier product
module fp_mul_arbiter
  import fp_mul_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned MUL_LATENCY = DEF_MUL_LATENCY
) (
  input  logic             clk,
  input  logic             rst_n,
  fp_mul_arbiter_if.slave  bus,
  input  logic             flush_req,
  output logic             flush_done,
  output logic             busy,
  output logic [FP_W-1:0]  mul_ay,
  output logic [FP_W-1:0]  mul_az,
  output logic             mul_ena,
  output logic             mul_clr,
  input  logic [FP_W-1:0]  mul_result
);

  localparam int unsigned ID_W  = clog2(NUM_REQ);
  localparam int unsigned CNT_W = clog2(MUL_LATENCY + 1);
  // Stage 0 sits beside the operand registers; stages 1..L track the DSP.
  localparam int unsigned TAG_N = MUL_LATENCY + 1;

  arb_state_e         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  fp_op_t             issue_q, issue_d;
  logic [TAG_N-1:0]   tag_vld_q, tag_vld_d;
  logic [ID_W-1:0]    tag_id_q [TAG_N];
  logic [ID_W-1:0]    tag_id_d [TAG_N];
  logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [FP_W-1:0]    rsp_data_q, rsp_data_d;
  logic               flush_done_q, flush_done_d;
  logic               busy_q, busy_d;
  logic               mul_ena_q, mul_ena_d;
  logic               mul_clr_q, mul_clr_d;

  logic [NUM_REQ-1:0] arb_req_c;
  logic [NUM_REQ-1:0] grant_c;
  logic [ID_W-1:0]    grant_id_c;
  logic               accept_c;

  // Arbitration only in RUN, and already masked in the cycle flush_req is seen.
  assign arb_req_c = (state_q == ST_RUN && !flush_req) ? bus.req_valid : '0;
  assign accept_c  = |grant_c;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (arb_req_c),
    .advance    (accept_c),
    .grant_c    (grant_c),
    .grant_id_c (grant_id_c)
  );

  // Sequencer: INIT/CLEAR hold clr for MUL_LATENCY cycles, DRAIN waits for empty tags.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    flush_done_d = 1'b0;
    unique case (state_q)
      ST_INIT: begin
        if (cnt_q == '0) state_d = ST_RUN;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      ST_RUN: begin
        if (flush_req) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (tag_vld_q == '0) begin
          state_d = ST_CLEAR;
          cnt_d   = CNT_W'(MUL_LATENCY - 1);
        end
      end
      ST_CLEAR: begin
        if (cnt_q == '0) begin
          state_d      = ST_RUN;
          flush_done_d = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = ST_INIT;
    endcase
    mul_ena_d = 1'b1;
    mul_clr_d = (state_d == ST_INIT) || (state_d == ST_CLEAR);
  end

  // Operand issue, tag pipeline and response routing.
  always_comb begin
    issue_d = issue_q;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (grant_c[i]) begin
        issue_d.a = bus.req_a[i*FP_W +: FP_W];
        issue_d.b = bus.req_b[i*FP_W +: FP_W];
      end
    end

    tag_vld_d = tag_vld_q;
    for (int s = 0; s < int'(TAG_N); s++) tag_id_d[s] = tag_id_q[s];
    if (mul_ena_q) begin
      tag_vld_d   = {tag_vld_q[TAG_N-2:0], accept_c};
      tag_id_d[0] = grant_id_c;
      for (int s = 1; s < int'(TAG_N); s++) tag_id_d[s] = tag_id_q[s-1];
    end

    rsp_valid_d = '0;
    rsp_data_d  = rsp_data_q;
    if (mul_ena_q && tag_vld_q[TAG_N-1]) begin
      rsp_valid_d = NUM_REQ'(1) << tag_id_q[TAG_N-1];
      rsp_data_d  = mul_result;
    end

    busy_d = !((state_d == ST_RUN) && (tag_vld_d == '0));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_INIT;
      cnt_q        <= CNT_W'(MUL_LATENCY - 1);
      issue_q      <= '0;
      tag_vld_q    <= '0;
      for (int s = 0; s < int'(TAG_N); s++) tag_id_q[s] <= '0;
      rsp_valid_q  <= '0;
      rsp_data_q   <= '0;
      flush_done_q <= 1'b0;
      busy_q       <= 1'b1;
      mul_ena_q    <= 1'b0;
      mul_clr_q    <= 1'b1;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      issue_q      <= issue_d;
      tag_vld_q    <= tag_vld_d;
      for (int s = 0; s < int'(TAG_N); s++) tag_id_q[s] <= tag_id_d[s];
      rsp_valid_q  <= rsp_valid_d;
      rsp_data_q   <= rsp_data_d;
      flush_done_q <= flush_done_d;
      busy_q       <= busy_d;
      mul_ena_q    <= mul_ena_d;
      mul_clr_q    <= mul_clr_d;
    end
  end

  assign bus.req_ready = grant_c;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign mul_ay        = issue_q.a;
  assign mul_az        = issue_q.b;
  assign mul_ena       = mul_ena_q;
  assign mul_clr       = mul_clr_q;
  assign flush_done    = flush_done_q;
  assign busy          = busy_q;

endmodule
